// File: rtl/seq_det_pkg.sv
// Shared types and constants for the 1010 detector path: serializer state encoding,
// default word width and the detector pattern.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [3:0] DET_PATTERN = 4'b1010;

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end for the 1010 detector; back-to-back words leave with no gap.
// Optional even-parity trailer bit per word when SERIAL_PARITY_EN is defined.
module seq_bit_serializer
  import seq_det_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             dout_o,
  output logic             dout_valid_o,
  output logic             busy_o
);

  // state  | meaning
  // IDLE   | line quiet, ready for a word
  // SHIFT  | driving data bit[count], count == WIDTH-1 is the last one
  // PARITY | driving the even-parity bit of the current word

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    count_q, count_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             at_last;
`ifdef SERIAL_PARITY_EN
  logic             parity_q, parity_d;
`endif

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  assign at_last = (count_q == LAST_IDX);
  assign accept  = in_valid_i & in_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      count_q      <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SERIAL_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
`ifdef SERIAL_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (at_last) begin
`ifdef SERIAL_PARITY_EN
          state_d = PARITY;
`else
          state_d = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SERIAL_PARITY_EN
      PARITY: begin
        state_d = accept ? SHIFT : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // The final cycle of a word is the zero-gap reload window.
  always_comb begin
    in_ready_o = 1'b0;
    case (state_q)
      IDLE:    in_ready_o = 1'b1;
`ifdef SERIAL_PARITY_EN
      SHIFT:   in_ready_o = 1'b0;
      PARITY:  in_ready_o = 1'b1;
`else
      SHIFT:   in_ready_o = at_last;
`endif
      default: in_ready_o = 1'b0;
    endcase
  end

  // The shift register holds the bits not yet on dout; dout_q is the bit on the line now.
  always_comb begin
    shreg_d      = shreg_q;
    count_d      = count_q;
    dout_d       = 1'b0;
    dout_valid_d = 1'b0;
    busy_d       = 1'b0;
`ifdef SERIAL_PARITY_EN
    parity_d     = parity_q;
`endif
    if (accept) begin
      shreg_d      = advance(in_data_i);
      count_d      = '0;
      dout_d       = head_bit(in_data_i);
      dout_valid_d = 1'b1;
      busy_d       = 1'b1;
`ifdef SERIAL_PARITY_EN
      parity_d     = ^in_data_i;
`endif
    end else if (state_q == SHIFT && !at_last) begin
      shreg_d      = advance(shreg_q);
      count_d      = count_q + CW'(1);
      dout_d       = head_bit(shreg_q);
      dout_valid_d = 1'b1;
      busy_d       = 1'b1;
    end
`ifdef SERIAL_PARITY_EN
    else if (state_q == SHIFT) begin
      shreg_d      = '0;
      count_d      = count_q + CW'(1);
      dout_d       = parity_q;
      dout_valid_d = 1'b1;
      busy_d       = 1'b1;
    end
`endif
    else begin
      shreg_d = '0;
      count_d = '0;
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: MSB-first and LSB-first instances share stimulus.
// Build with SERIAL_PARITY_EN defined to exercise the parity trailer.
module tb_seq_bit_serializer;
  import seq_det_pkg::*;

`ifdef SERIAL_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int NBITS  = 18;
  localparam logic [17:0] EXP_STREAM_M = 18'b00001010_0_10100000_0;
  localparam logic [17:0] EXP_STREAM_L = 18'b01010000_0_00000101_0;
  localparam int EXP_HIT2 = 13;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int NBITS  = 16;
  localparam logic [17:0] EXP_STREAM_M = 18'b00_00001010_10100000;
  localparam logic [17:0] EXP_STREAM_L = 18'b00_01010000_00000101;
  localparam int EXP_HIT2 = 12;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       rdy_m, dout_m, dv_m, busy_m;
  logic       rdy_l, dout_l, dv_l, busy_l;

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(rdy_m), .dout_o(dout_m), .dout_valid_o(dv_m), .busy_o(busy_m)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(rdy_l), .dout_o(dout_l), .dout_valid_o(dv_l), .busy_o(busy_l)
  );

  // Bit sequences are written in emission order, left to right.
  typedef struct {
    logic [7:0] word;
    logic [7:0] msb_seq;
    logic [7:0] lsb_seq;
    logic       par;
  } vec_t;

  vec_t vecs[6];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " dout_m"}, 32'(dout_m), 32'd0);
    check({tag, " dv_m"},   32'(dv_m),   32'd0);
    check({tag, " busy_m"}, 32'(busy_m), 32'd0);
    check({tag, " rdy_m"},  32'(rdy_m),  32'd1);
    check({tag, " dout_l"}, 32'(dout_l), 32'd0);
    check({tag, " dv_l"},   32'(dv_l),   32'd0);
    check({tag, " busy_l"}, 32'(busy_l), 32'd0);
    check({tag, " rdy_l"},  32'(rdy_l),  32'd1);
  endtask

  task automatic run_word(input vec_t v);
    logic exp_rdy;
    @(negedge clk);
    in_data  = v.word;
    in_valid = 1'b1;
    check($sformatf("w%02h ready_before", v.word), 32'(rdy_m & rdy_l), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_rdy = (k == 7) && !PAR_EN;
      check($sformatf("w%02h dout_m[%0d]", v.word, k), 32'(dout_m), 32'(v.msb_seq[7-k]));
      check($sformatf("w%02h dout_l[%0d]", v.word, k), 32'(dout_l), 32'(v.lsb_seq[7-k]));
      check($sformatf("w%02h dv[%0d]", v.word, k),     32'({dv_m, dv_l, busy_m, busy_l}), 32'hF);
      check($sformatf("w%02h rdy_m[%0d]", v.word, k),  32'(rdy_m), 32'(exp_rdy));
      check($sformatf("w%02h rdy_l[%0d]", v.word, k),  32'(rdy_l), 32'(exp_rdy));
    end
    if (PAR_EN) begin
      @(negedge clk);
      check($sformatf("w%02h par_m", v.word), 32'(dout_m), 32'(v.par));
      check($sformatf("w%02h par_l", v.word), 32'(dout_l), 32'(v.par));
      check($sformatf("w%02h par_dv", v.word), 32'({dv_m, dv_l, rdy_m, rdy_l}), 32'hF);
    end
    @(negedge clk);
    check_idle($sformatf("w%02h after", v.word));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [17:0] s_m, s_l;
    int          n_m, n_l, first_m, last_m, nacc, idx;
    logic        will;
    logic [3:0]  win;
    int          fill, nhits, hit1, hit2;

    vecs[0] = '{word: 8'hA5, msb_seq: 8'b10100101, lsb_seq: 8'b10100101, par: 1'b0};
    vecs[1] = '{word: 8'h05, msb_seq: 8'b00000101, lsb_seq: 8'b10100000, par: 1'b0};
    vecs[2] = '{word: 8'h0A, msb_seq: 8'b00001010, lsb_seq: 8'b01010000, par: 1'b0};
    vecs[3] = '{word: 8'h80, msb_seq: 8'b10000000, lsb_seq: 8'b00000001, par: 1'b1};
    vecs[4] = '{word: 8'h07, msb_seq: 8'b00000111, lsb_seq: 8'b11100000, par: 1'b1};
    vecs[5] = '{word: 8'h03, msb_seq: 8'b00000011, lsb_seq: 8'b11000000, par: 1'b0};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    for (int i = 0; i < 6; i++) run_word(vecs[i]);

    // Back-to-back 0A then A0 with in_valid held high.
    @(posedge clk);
    #1;
    in_data  = 8'h0A;
    in_valid = 1'b1;
    s_m = '0; s_l = '0; n_m = 0; n_l = 0; first_m = -1; last_m = -1; nacc = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (dv_m) begin
        s_m = {s_m[16:0], dout_m};
        n_m++;
        if (first_m < 0) first_m = c;
        last_m = c;
      end
      if (dv_l) begin
        s_l = {s_l[16:0], dout_l};
        n_l++;
      end
      will = in_valid & rdy_m;
      @(posedge clk);
      #1;
      if (will) begin
        nacc++;
        if (nacc == 1) in_data = 8'hA0;
        else begin
          in_valid = 1'b0;
          in_data  = 8'h00;
        end
      end
    end
    in_valid = 1'b0;
    check("b2b accepts", 32'(nacc), 32'd2);
    check("b2b nbits_m", 32'(n_m), 32'(NBITS));
    check("b2b nbits_l", 32'(n_l), 32'(NBITS));
    check("b2b contiguous", 32'(last_m - first_m + 1), 32'(NBITS));
    check("b2b stream_m", 32'(s_m), 32'(EXP_STREAM_M));
    check("b2b stream_l", 32'(s_l), 32'(EXP_STREAM_L));

    // Non-overlapping 1010 detector over the MSB-first valid stream.
    win = '0; fill = 0; nhits = 0; hit1 = 0; hit2 = 0;
    for (int i = 0; i < NBITS; i++) begin
      idx = NBITS - 1 - i;
      win = {win[2:0], s_m[idx]};
      fill++;
      if (fill >= 4 && win == DET_PATTERN) begin
        nhits++;
        if (nhits == 1) hit1 = i + 1;
        if (nhits == 2) hit2 = i + 1;
        fill = 0;
        win  = '0;
      end
    end
    check("det hits", 32'(nhits), 32'd2);
    check("det hit1", 32'(hit1), 32'd8);
    check("det hit2", 32'(hit2), 32'(EXP_HIT2));
    @(negedge clk);
    check_idle("b2b after");

    // Reset in the middle of 8'hFF.
    @(negedge clk);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort bit3", 32'({dout_m, dv_m, dout_l, dv_l}), 32'hF);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("abort");
    run_word(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
